bram_reader: RTL and testbench
==============================

# bram_reader

Read-side stream engine for the dual-port block RAM. Given a start address and word count, it issues reads on the RAM read port, absorbs the RAM's two-cycle registered read latency in a 4-entry skid FIFO, and presents the words on a valid/ready stream. It sits between the RAM's read port and any downstream consumer, such as a DMA egress path or a host readback, and allows full-rate readout under arbitrary backpressure.

## Interface
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 10, RAM address width; the RAM holds 2^ADDR_WIDTH words.
- FIFO_DEPTH, 4, skid FIFO entries; fixed at 4 and not user-tunable.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_address  in  ADDR_WIDTH  first word address; sampled with start.
- count  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- out_data  out  DATA_WIDTH  stream word (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- bram_en  out  1  RAM enable. High whenever busy. The integrator ORs it with the writer's enable.
- bram_read_address  out  ADDR_WIDTH  RAM read address.
- bram_data_in  in  DATA_WIDTH  RAM data_out.

## Operation
- RAM contract:
  - While the RAM enable is held high, an address driven in cycle t returns data on bram_data_in in cycle t+2.
  - The reader holds bram_en high for the entire busy period, so the RAM pipeline never freezes.
- States: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ: start && count!=0. Load the address and the remaining-to-issue counter; issue starts in the next cycle.
  - IDLE -> DONE: start && count==0. No RAM reads are issued.
  - READ -> DRAIN: the last read is issued.
  - DRAIN -> DONE: in-flight count is 0, the FIFO is empty, and the last word has been accepted.
  - DONE -> IDLE: unconditional. done=1 for exactly this one cycle.
- Issue rule: issue in a READ cycle iff inflight + fifo_count < 4.
  - Issuing drives bram_read_address = current address, then increments the address and decrements the remaining counter.
  - Non-issue cycles hold the address.
- In-flight tracking:
  - A 2-stage valid shift register tags each cycle's issue.
  - A tag emerging at stage 2 pushes bram_data_in into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
- Address arithmetic is modulo 2^ADDR_WIDTH, so the address wraps from max to 0. count=2^ADDR_WIDTH reads every word exactly once.
- start while busy (any state but IDLE) is ignored entirely.
- Reset, including mid-transfer:
  - Next state is IDLE.
  - FIFO, tags and counters are cleared; in-flight RAM data is discarded.
  - Outputs take their reset values: busy=0, done=0, out_valid=0, out_data=0, bram_en=0, bram_read_address=0.

## Timing
- Start sampled in cycle 0. First issue occurs in cycle 1.
  - Data returns in cycle 3 and is pushed at the end of cycle 3.
  - out_valid=1 in cycle 4. Start-to-first-word latency is 4 cycles.
- With out_ready held high: one word per cycle, sustained (steady state inflight=2, fifo=1).
- Backpressure:
  - out_data and out_valid stay stable while out_valid && !out_ready.
  - Issue stalls when the credit limit is reached, and resumes the cycle after a pop frees a credit.
- Word order on the stream equals address order. Every issued word is delivered exactly once.
- done asserts the cycle after the final handshake. busy falls in that same cycle.
- count==0: done pulses in cycle 1; busy stays 0; bram_en stays 0.

## Test plan
- RAM preloaded with mem[a]=a+0x100. Start with start_address=0x010, count=4, out_ready=1.
  - out_valid in cycles 4-7 with data 0x110, 0x111, 0x112, 0x113.
  - done in cycle 8.
- Same transfer with out_ready toggling 1,0,0,1,...
  - Data is never dropped or duplicated; out_data is held while stalled.
  - inflight+fifo never exceeds 4.
- Wrap-around: start_address=0x3FE, count=4.
  - Reads addresses 0x3FE, 0x3FF, 0x000, 0x001 in that order.
- count=0: done in cycle 1, with no out_valid and no bram_en.
  - count=1024: all 1024 words delivered in address order; done one cycle after the last word.
- Assert rst in the third cycle of a 16-word transfer.
  - Next cycle: all outputs at reset values and no further out_valid.
  - A fresh start afterwards delivers correct data.
- Pulse start again while busy with a different address.
  - Ignored: the original transfer completes unchanged and done pulses once.

Source files
------------

// File: rtl/bram_reader.sv
// bram_reader: streams a run of words out of the block RAM read port.
// Issues one read per cycle while credits allow, tags each issue through
// the RAM's two-cycle latency and catches the returning data in a 4-entry
// skid FIFO whose head drives the valid/ready output stream.
module bram_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_read_address,
  input  logic [DATA_WIDTH-1:0] bram_data_in
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]            CREDITS   = 3'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  tag1_q, tag1_d;
  logic                  tag2_q, tag2_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [0:3];
  logic [DATA_WIDTH-1:0] fifo_mem_d [0:3];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_count_q, fifo_count_d;

  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic [2:0]            inflight_s;
  logic                  credit_ok_s;
  logic                  drain_done_s;
  logic                  fifo_nonempty_s;

  // Credit accounting, stream handshake and drain-complete detection.
  always_comb begin
    inflight_s      = {2'b00, tag1_q} + {2'b00, tag2_q};
    credit_ok_s     = ((inflight_s + fifo_count_q) < CREDITS);
    fifo_nonempty_s = (fifo_count_q != 3'd0);
    pop_s           = fifo_nonempty_s && out_ready;
    push_s          = tag2_q;
    // With nothing in flight no push can arrive, so the FIFO is finished
    // once it is empty or its last word leaves this cycle.
    drain_done_s    = (inflight_s == 3'd0) &&
                      ((fifo_count_q == 3'd0) || ((fifo_count_q == 3'd1) && pop_s));
  end

  // Transfer FSM: next state, read issue and address/remaining counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != CNT_ZERO) begin
            state_d     = ST_READ;
            addr_d      = start_address;
            remaining_d = count;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (credit_ok_s) begin
          issue_s     = 1'b1;
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latency tags and skid FIFO update.
  always_comb begin
    tag1_d       = issue_s;
    tag2_d       = tag1_q;
    fifo_mem_d   = fifo_mem_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = bram_data_in;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + 3'd1;
      2'b01:   fifo_count_d = fifo_count_q - 3'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // State register with synchronous reset; reset discards in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      remaining_q  <= CNT_ZERO;
      tag1_q       <= 1'b0;
      tag2_q       <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      fifo_count_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= DATA_ZERO;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    busy              = (state_q == ST_READ) || (state_q == ST_DRAIN);
    bram_en           = busy;
    done              = (state_q == ST_DONE);
    bram_read_address = addr_q;
    out_valid         = fifo_nonempty_s;
    if (fifo_nonempty_s) begin
      out_data = fifo_mem_q[rd_ptr_q];
    end else begin
      out_data = DATA_ZERO;
    end
  end

endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader: a 2-cycle-latency RAM model, an
// expected-word queue built from RAM contents and address arithmetic, and
// directed plus randomized transfers under several backpressure patterns.
module tb_bram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_address;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bram_en;
  logic [9:0]  bram_read_address;
  logic [31:0] bram_data_in;

  logic [31:0] mem [0:1023];
  logic [31:0] rd1, rd2;
  logic [31:0] exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  bram_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address),
    .count(count), .busy(busy), .done(done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .bram_en(bram_en),
    .bram_read_address(bram_read_address), .bram_data_in(bram_data_in)
  );

  always #5 clk = ~clk;

  // RAM read port: address in cycle t returns data in cycle t+2 while enabled.
  always @(posedge clk) begin
    if (bram_en) begin
      rd1 <= mem[bram_read_address];
      rd2 <= rd1;
    end
  end
  assign bram_data_in = rd2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    else if (mode == 1) return ((c % 3) == 1);
    else return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer from start to the cycle after done, checked against the
  // expected-word queue. mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random.
  task automatic run_transfer(input logic [9:0] sa, input logic [10:0] cnt,
                              input int mode, input int pulse_cyc, input string name);
    int c = 0, done_cnt = 0, done_c = -1, first_v = -1, last_pop = -1;
    int popped = 0, issued, bound;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    bit valid_seen = 0, en_seen = 0, busy_seen = 0, finished = 0;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(mem[10'((int'(sa) + i) % 1024)]);
    bound = int'(cnt) * 4 + 40;
    start = 1'b1; start_address = sa; count = cnt; out_ready = ready_for(mode, 0);
    while (!finished && c < bound) begin
      tick();
      c++;
      if (c == pulse_cyc) begin
        start = 1'b1; start_address = sa ^ 10'h155; count = 11'd7;
      end else begin
        start = 1'b0;
      end
      out_ready = ready_for(mode, c);
      if (out_valid) valid_seen = 1;
      if (bram_en) en_seen = 1;
      if (busy) busy_seen = 1;
      if (prev_stall) begin
        check({name, " hold valid"}, out_valid, 1'b1);
        check({name, " hold data"}, out_data, prev_data);
      end
      if (mode == 0 && cnt != 11'd0 && c >= 4 && c < int'(cnt) + 4)
        check({name, " full-rate valid"}, out_valid, 1'b1);
      if (busy) begin
        check({name, " bram_en while busy"}, bram_en, 1'b1);
        if (cnt != 11'd1024) begin
          issued = int'(10'(bram_read_address - sa));
          check({name, " credit limit"}, ((issued - popped) <= 4), 1'b1);
        end
      end
      if (out_valid && out_ready) begin
        if (first_v < 0) first_v = c;
        if (exp_q.size() == 0) check({name, " extra word"}, popped + 1, cnt);
        else check({name, " data"}, out_data, exp_q.pop_front());
        popped++;
        last_pop = c;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        done_c = c;
        check({name, " busy low at done"}, busy, 1'b0);
        finished = 1;
      end else if (cnt != 11'd0) begin
        check({name, " busy before done"}, busy, 1'b1);
      end
    end
    check({name, " completed in bound"}, finished, 1'b1);
    tick();
    start = 1'b0;
    check({name, " done single pulse"}, done, 1'b0);
    check({name, " idle busy"}, busy, 1'b0);
    check({name, " idle valid"}, out_valid, 1'b0);
    check({name, " words left"}, exp_q.size(), 0);
    check({name, " done count"}, done_cnt, 1);
    if (cnt != 11'd0) begin
      check({name, " done after last word"}, done_c, last_pop + 1);
      if (mode == 0) begin
        check({name, " first word cycle"}, first_v, 4);
        check({name, " done cycle"}, done_c, int'(cnt) + 4);
      end
    end else begin
      check({name, " zero done cycle"}, done_c, 1);
      check({name, " zero no valid"}, valid_seen, 1'b0);
      check({name, " zero no bram_en"}, en_seen, 1'b0);
      check({name, " zero no busy"}, busy_seen, 1'b0);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'(a) + 32'h100;
    rst = 1'b1; start = 1'b0; start_address = 10'd0; count = 11'd0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 32'd0);
    check("reset bram_en", bram_en, 1'b0);
    check("reset bram_read_address", bram_read_address, 10'd0);
    rst = 1'b0;
    tick();

    run_transfer(10'h010, 11'd4, 0, 0, "basic");
    run_transfer(10'h010, 11'd4, 1, 0, "toggle4");
    run_transfer(10'h010, 11'd12, 1, 0, "toggle12");
    run_transfer(10'h3FE, 11'd4, 0, 0, "wrap");
    run_transfer(10'h123, 11'd0, 0, 0, "zero");
    run_transfer(10'h155, 11'd1024, 0, 0, "full");

    // Reset in the third cycle of a 16-word transfer.
    start = 1'b1; start_address = 10'h020; count = 11'd16; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset out_data", out_data, 32'd0);
    check("midreset bram_en", bram_en, 1'b0);
    check("midreset bram_read_address", bram_read_address, 10'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post-reset quiet valid", out_valid, 1'b0);
      check("post-reset quiet busy", busy, 1'b0);
    end
    run_transfer(10'h020, 11'd16, 0, 0, "after-reset");

    run_transfer(10'h040, 11'd8, 0, 3, "start-while-busy");

    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    for (int t = 0; t < 12; t++) begin
      run_transfer(10'($urandom), 11'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 12)), $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
